// File: rtl/trace_pkg.sv
// Shared types for the retirement trace sink: the record layout handed to the
// ISS comparator / trace logger, plus privilege-mode encodings.
package trace_pkg;

   localparam int SEQ_W = 32;

   localparam logic [2:0] PRIV_U = 3'd0;
   localparam logic [2:0] PRIV_S = 3'd1;
   localparam logic [2:0] PRIV_M = 3'd3;

   typedef struct packed {
      logic [SEQ_W-1:0] seq;
      logic             gap;
      logic             excpt;
      logic [2:0]       priv_mode;
      logic [31:0]      pc;
      logic [31:0]      inst;
      logic [4:0]       wrdst;
      logic [31:0]      wrdata;
      logic             wrenx;
      logic             wrenf;
      logic [31:0]      timer;
   } trace_rec_t;

   localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO with a registered head word that reads as zero when
// empty. A push into a full FIFO is accepted only if a pop happens the same cycle.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_next;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_next;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] head_next;
   logic             push_ok;
   logic             pop_ok;

   assign valid = (level_q != '0);
   assign full  = (level_q == LW'(DEPTH));
   assign level = level_q;
   assign head  = head_q;

   always_comb begin
      push_ok    = push & (~full | pop);
      pop_ok     = pop & valid;
      rd_next    = rd_ptr + AW'(1);
      level_next = level_q + LW'(push_ok) - LW'(pop_ok);
      head_next  = head_q;
      // The next head is either the entry behind the current one or, when that
      // slot is being written this very cycle, the incoming word.
      if (level_next == '0)
         head_next = '0;
      else if (pop_ok)
         head_next = (level_q == LW'(1)) ? push_data : mem[rd_next];
      else if (level_q == '0)
         head_next = push_data;
   end

   always_ff @(posedge clock) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         level_q <= '0;
         head_q  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_next;
         level_q <= level_next;
         head_q  <= head_next;
      end
   end

endmodule

// File: rtl/retire_trace_sink.sv
// Samples one retirement per cycle from the core's tap, stamps it with a
// sequence number and gap flag, and queues it for a valid/ready consumer.
module retire_trace_sink
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     capture_en,
   input  logic                     tap_valid,
   input  logic                     tap_excpt,
   input  logic [2:0]               tap_priv_mode,
   input  logic [31:0]              tap_pc,
   input  logic [31:0]              tap_inst,
   input  logic [4:0]               tap_wrdst,
   input  logic [31:0]              tap_wrdata,
   input  logic                     tap_wrenx,
   input  logic                     tap_wrenf,
   input  logic [31:0]              tap_timer,
   output logic                     out_valid,
   input  logic                     out_ready,
   output trace_rec_t               out_rec,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   // Stream handshake: a record transfers on a cycle where out_valid and
   // out_ready are both high; out_rec holds steady while valid waits on ready.

   logic [SEQ_W-1:0] seq;
   logic             gap_pend;
   logic             push;
   logic             pop;
   logic             drop;
   logic             accept;
   logic             fifo_full;
   trace_rec_t       rec_in;
   logic [REC_W-1:0] head_bits;

   always_comb begin
      push   = capture_en & tap_valid;
      pop    = out_valid & out_ready;
      drop   = push & fifo_full & ~pop;
      accept = push & ~drop;

      rec_in           = '0;
      rec_in.seq       = seq;
      rec_in.gap       = gap_pend;
      rec_in.excpt     = tap_excpt;
      rec_in.priv_mode = tap_priv_mode;
      rec_in.pc        = tap_pc;
      rec_in.inst      = tap_inst;
      rec_in.wrdst     = tap_wrdst;
      rec_in.wrdata    = tap_wrdata;
      rec_in.wrenx     = tap_wrenx;
      rec_in.wrenf     = tap_wrenf;
      rec_in.timer     = tap_timer;
   end

   trace_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (accept),
      .push_data (rec_in),
      .pop       (pop),
      .head      (head_bits),
      .valid     (out_valid),
      .full      (fifo_full),
      .level     (level)
   );

   assign out_rec = trace_rec_t'(head_bits);

   // A drop leaves seq alone so the consumer sees a contiguous numbering of
   // what it actually received, with gap marking where history went missing.
   always_ff @(posedge clock) begin
      if (reset) begin
         seq      <= '0;
         gap_pend <= 1'b0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            seq      <= seq + SEQ_W'(1);
            gap_pend <= 1'b0;
         end
         if (drop) begin
            gap_pend <= 1'b1;
            overflow <= 1'b1;
            if (drop_cnt != '1)
               drop_cnt <= drop_cnt + CNT_W'(1);
         end
      end
   end

endmodule
